// File: rtl/rega_sched_if.sv
// Sensor, request and scheduler-output bundle between the irrigation scheduler
// and whatever drives its inputs.
interface rega_sched_if;
  logic       tick;
  logic       Seco;
  logic       Chuva;
  logic       Adub_req;
  logic       Alm_ack;
  logic       Asp;
  logic       Adub;
  logic       Alarm;
  logic [1:0] Est;

  modport master (output tick, Seco, Chuva, Adub_req, Alm_ack,
                  input  Asp, Adub, Alarm, Est);
  modport slave  (input  tick, Seco, Chuva, Adub_req, Alm_ack,
                  output Asp, Adub, Alarm, Est);
endinterface

// File: rtl/rega_sched.sv
// Irrigation scheduler: conditions soil/rain sensors, runs IDLE/IRRIG/COOL
// sessions bounded by MIN_ON/MAX_ON ticks, and raises a sticky timeout alarm.
module rega_sched #(
  parameter int DEB_CYCLES = 4,
  parameter int MIN_ON     = 8,
  parameter int MAX_ON     = 32,
  parameter int COOLDOWN   = 16,
  parameter int CNT_W      = 8
) (
  input  logic        clk,
  input  logic        reset,
  rega_sched_if.slave bus
);
  localparam int NUM_LANES = 2;  // debounced lanes: 0 = Seco, 1 = Chuva
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_ON);
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(MAX_ON - 1);
  localparam logic [CNT_W-1:0] CD_LAST  = CNT_W'(COOLDOWN - 1);

  typedef enum logic [1:0] {IDLE = 2'b00, IRRIG = 2'b01, COOL = 2'b10} state_t;

  state_t                          state_q, state_d;
  logic [2:0]                      sync1_q, sync2_q;  // {Adub_req, Chuva, Seco}
  logic [NUM_LANES-1:0]            filt_q, filt_d;
  logic [NUM_LANES-1:0][CNT_W-1:0] deb_q, deb_d;
  logic [CNT_W-1:0]                on_q, on_d, cd_q, cd_d;
  logic                            req_prev_q, pend_q, pend_d;
  logic                            adub_q, adub_d, alarm_q, alarm_d;
  logic                            req_rise, alarm_set, dry, rain;

  assign dry      = filt_q[0];
  assign rain     = filt_q[1];
  assign req_rise = sync2_q[2] & ~req_prev_q;

  always_comb begin
    filt_d = filt_q;
    deb_d  = deb_q;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (sync2_q[l] == filt_q[l]) begin
        deb_d[l] = '0;
      end else if (deb_q[l] == DEB_LAST) begin
        filt_d[l] = ~filt_q[l];
        deb_d[l]  = '0;
      end else begin
        deb_d[l] = deb_q[l] + ONE;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    on_d      = on_q;
    cd_d      = cd_q;
    adub_d    = adub_q;
    alarm_set = 1'b0;
    pend_d    = pend_q | req_rise;
    case (state_q)
      IDLE: begin
        if (dry && !rain && !alarm_q) begin
          state_d = IRRIG;
          on_d    = '0;
          adub_d  = pend_q;
          // an edge coinciding with the start is kept for the next session
          pend_d  = req_rise & ~pend_q;
        end
      end
      IRRIG: begin
        if (bus.tick) on_d = on_q + ONE;
        if (bus.tick && on_q == ON_LAST) begin
          state_d   = COOL;
          alarm_set = 1'b1;
        end else if (rain || (on_q >= MIN_C && !dry)) begin
          state_d = COOL;
        end
        if (state_d == COOL) begin
          adub_d = 1'b0;
          cd_d   = '0;
        end
      end
      COOL: begin
        if (bus.tick) begin
          if (cd_q == CD_LAST) state_d = IDLE;
          else                 cd_d    = cd_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase
    alarm_d = alarm_set | (alarm_q & ~bus.Alm_ack);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sync1_q    <= '0;
      sync2_q    <= '0;
      filt_q     <= '0;
      deb_q      <= '0;
      on_q       <= '0;
      cd_q       <= '0;
      req_prev_q <= 1'b0;
      pend_q     <= 1'b0;
      adub_q     <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= {bus.Adub_req, bus.Chuva, bus.Seco};
      sync2_q    <= sync1_q;
      filt_q     <= filt_d;
      deb_q      <= deb_d;
      on_q       <= on_d;
      cd_q       <= cd_d;
      req_prev_q <= sync2_q[2];
      pend_q     <= pend_d;
      adub_q     <= adub_d;
      alarm_q    <= alarm_d;
    end
  end

  assign bus.Asp   = (state_q == IRRIG);
  assign bus.Adub  = adub_q;
  assign bus.Alarm = alarm_q;
  assign bus.Est   = state_q;
endmodule

// File: tb/tb_rega_sched.sv
// Bench for rega_sched: directed scenarios plus randomized traffic, all compared
// against a cycle model built from sample histories and run lengths.
module tb_rega_sched;
  localparam int DEB = 4, MIN_ON = 8, MAX_ON = 32, CD = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  rega_sched_if bus();

  rega_sched #(.DEB_CYCLES(DEB), .MIN_ON(MIN_ON), .MAX_ON(MAX_ON),
               .COOLDOWN(CD), .CNT_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // reference model: raw sample histories, run lengths, session bookkeeping
  bit   hs[$], hc[$], hr[$];
  int   m_mode, m_on, m_cd, m_rs, m_rc;
  bit   m_sf, m_cf, m_alarm, m_adub, m_pend;
  logic [1:0] pre_est;
  int   gap;

  function automatic bit hist(input bit q[$], input int k);
    return (q.size() >= k) ? q[q.size() - k] : 1'b0;
  endfunction

  function automatic logic [4:0] expv();
    return {m_mode == 1, m_adub, m_alarm, 2'(m_mode)};
  endfunction

  function automatic logic [4:0] obsv();
    return {bus.Asp, bus.Adub, bus.Alarm, bus.Est};
  endfunction

  task automatic model_edge();
    bit ss, sc, sr, srp, rise, start, setal;
    int nmode;
    if (reset) begin
      hs.delete(); hc.delete(); hr.delete();
      m_mode = 0; m_on = 0; m_cd = 0; m_rs = 0; m_rc = 0;
      m_sf = 0; m_cf = 0; m_alarm = 0; m_adub = 0; m_pend = 0;
      return;
    end
    // synchronised view = raw value captured two edges earlier
    ss = hist(hs, 2); sc = hist(hc, 2); sr = hist(hr, 2); srp = hist(hr, 3);
    rise = sr && !srp;
    start = 0; setal = 0; nmode = m_mode;
    case (m_mode)
      0: if (m_sf && !m_cf && !m_alarm) begin
           nmode = 1; m_on = 0; m_adub = m_pend; start = 1;
         end
      1: begin
           if (bus.tick && m_on == MAX_ON - 1) setal = 1;
           if (setal || m_cf || (m_on >= MIN_ON && !m_sf)) begin
             nmode = 2; m_cd = 0; m_adub = 0;
           end else if (bus.tick) m_on++;
         end
      default: if (bus.tick) begin
                 if (m_cd == CD - 1) nmode = 0; else m_cd++;
               end
    endcase
    m_pend  = start ? (rise && !m_pend) : (m_pend || rise);
    m_alarm = setal ? 1'b1 : (bus.Alm_ack ? 1'b0 : m_alarm);
    m_mode  = nmode;
    // filtered value flips after DEB consecutive disagreeing samples
    if (ss != m_sf) begin m_rs++; if (m_rs == DEB) begin m_sf = !m_sf; m_rs = 0; end end
    else m_rs = 0;
    if (sc != m_cf) begin m_rc++; if (m_rc == DEB) begin m_cf = !m_cf; m_rc = 0; end end
    else m_rc = 0;
    hs.push_back(bus.Seco); hc.push_back(bus.Chuva); hr.push_back(bus.Adub_req);
    if (hs.size() > 4) begin void'(hs.pop_front()); void'(hc.pop_front()); void'(hr.pop_front()); end
  endtask

  task automatic cyc(input bit t);
    bus.tick = t;
    pre_est = bus.Est;
    @(posedge clk);
    model_edge();
    #1;
    bus.tick = 1'b0;
  endtask

  function automatic bit next_tick();
    bit t;
    t = (gap == 0);
    gap = t ? int'($urandom_range(1, 3)) : gap - 1;
    return t;
  endfunction

  task automatic start_session();
    bus.Seco = 1'b1; bus.Chuva = 1'b0;
    for (int i = 0; i < 20 && !bus.Asp; i++) cyc(1'b0);
    checks++;
    if (bus.Asp !== 1'b1) begin errors++; $display("FAIL start_session Asp=%b want 1", bus.Asp); end
  endtask

  task automatic end_session();
    bus.Seco = 1'b0; bus.Chuva = 1'b0;
    for (int i = 0; i < 600 && !(bus.Est == 2'b00 && pre_est == 2'b10); i++) cyc(next_tick());
    checks++;
    if (bus.Est !== 2'b00) begin errors++; $display("FAIL end_session Est=%b want 00", bus.Est); end
  endtask

  task automatic pulse_req();
    bus.Adub_req = 1'b1; cyc(0); cyc(0);
    bus.Adub_req = 1'b0; repeat (4) cyc(0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cyc(0);
    checks++; if (bus.Asp   !== 1'b0)  begin errors++; $display("FAIL reset_asp got %b want 0", bus.Asp); end
    checks++; if (bus.Adub  !== 1'b0)  begin errors++; $display("FAIL reset_adub got %b want 0", bus.Adub); end
    checks++; if (bus.Alarm !== 1'b0)  begin errors++; $display("FAIL reset_alarm got %b want 0", bus.Alarm); end
    checks++; if (bus.Est   !== 2'b00) begin errors++; $display("FAIL reset_est got %b want 00", bus.Est); end
    reset = 1'b0;
    cyc(0);
  endtask

  task automatic test_latency();
    int n;
    bus.Seco = 1'b1;
    for (n = 1; n <= 20; n++) begin cyc(0); if (bus.Asp) break; end
    checks++; if (n != DEB + 3) begin errors++; $display("FAIL latency got %0d want %0d", n, DEB + 3); end
    checks++; if (bus.Est !== 2'b01 || bus.Adub !== 1'b0)
      begin errors++; $display("FAIL latency_est got Est=%b Adub=%b want 01/0", bus.Est, bus.Adub); end
    checks++; if (obsv() !== expv()) begin errors++; $display("FAIL latency_model got %b want %b", obsv(), expv()); end
    end_session();
  endtask

  task automatic test_glitch();
    bit seen = 0;
    bus.Seco = 1'b1; repeat (3) cyc(0);
    bus.Seco = 1'b0;
    repeat (20) begin cyc(0); if (bus.Asp) seen = 1; end
    checks++; if (seen) begin errors++; $display("FAIL glitch Asp rose, want stay 0"); end
    checks++; if (obsv() !== expv()) begin errors++; $display("FAIL glitch_model got %b want %b", obsv(), expv()); end
  endtask

  task automatic test_min_on();
    int irr = 0, cool = 0;
    bit t, seen_cool = 0;
    start_session();
    repeat (3) begin cyc(1); irr++; cyc(0); end
    bus.Seco = 1'b0;
    for (int i = 0; i < 600 && !(seen_cool && bus.Est == 2'b00); i++) begin
      t = next_tick();
      cyc(t);
      if (t && pre_est == 2'b01 && bus.Est == 2'b01) irr++;
      if (t && pre_est == 2'b10) cool++;
      if (bus.Est == 2'b10) seen_cool = 1;
    end
    checks++; if (irr != MIN_ON) begin errors++; $display("FAIL min_on ticks got %0d want %0d", irr, MIN_ON); end
    checks++; if (cool != CD) begin errors++; $display("FAIL cooldown ticks got %0d want %0d", cool, CD); end
    checks++; if (obsv() !== expv() || bus.Est !== 2'b00)
      begin errors++; $display("FAIL min_on_model got %b want %b", obsv(), expv()); end
  endtask

  task automatic test_rain();
    int n;
    start_session();
    cyc(1); cyc(0); cyc(1); cyc(0);
    bus.Chuva = 1'b1;
    for (n = 1; n <= 20; n++) begin cyc(0); if (!bus.Asp) break; end
    checks++; if (n != DEB + 3) begin errors++; $display("FAIL rain_exit got %0d want %0d", n, DEB + 3); end
    checks++; if (bus.Alarm !== 1'b0 || bus.Est !== 2'b10)
      begin errors++; $display("FAIL rain_state got Alarm=%b Est=%b want 0/10", bus.Alarm, bus.Est); end
    checks++; if (obsv() !== expv()) begin errors++; $display("FAIL rain_model got %b want %b", obsv(), expv()); end
    end_session();
  endtask

  task automatic test_timeout();
    int ticks = 0;
    bit t, seen = 0;
    start_session();
    for (int i = 0; i < 400 && bus.Asp; i++) begin
      t = next_tick(); cyc(t); if (t && pre_est == 2'b01) ticks++;
    end
    checks++; if (ticks != MAX_ON) begin errors++; $display("FAIL timeout_ticks got %0d want %0d", ticks, MAX_ON); end
    checks++; if (bus.Alarm !== 1'b1 || bus.Est !== 2'b10)
      begin errors++; $display("FAIL timeout_alarm got Alarm=%b Est=%b want 1/10", bus.Alarm, bus.Est); end
    for (int i = 0; i < 400 && bus.Est != 2'b00; i++) cyc(next_tick());
    repeat (12) begin cyc(0); if (bus.Asp) seen = 1; end
    checks++; if (seen || bus.Alarm !== 1'b1 || bus.Est !== 2'b00)
      begin errors++; $display("FAIL alarm_block got Asp_seen=%b Alarm=%b Est=%b want 0/1/00", seen, bus.Alarm, bus.Est); end
    bus.Alm_ack = 1'b1; cyc(0); bus.Alm_ack = 1'b0;
    checks++; if (bus.Alarm !== 1'b0) begin errors++; $display("FAIL ack_clear got %b want 0", bus.Alarm); end
    cyc(0);
    checks++; if (bus.Asp !== 1'b1) begin errors++; $display("FAIL ack_restart got Asp=%b want 1", bus.Asp); end
    ticks = 0;
    for (int i = 0; i < 400 && bus.Asp; i++) begin
      t = next_tick();
      if (t && ticks == MAX_ON - 1) bus.Alm_ack = 1'b1;
      cyc(t);
      bus.Alm_ack = 1'b0;
      if (t && pre_est == 2'b01) ticks++;
    end
    checks++; if (bus.Alarm !== 1'b1 || bus.Est !== 2'b10)
      begin errors++; $display("FAIL ack_vs_set got Alarm=%b Est=%b want 1/10", bus.Alarm, bus.Est); end
    checks++; if (obsv() !== expv()) begin errors++; $display("FAIL timeout_model got %b want %b", obsv(), expv()); end
    end_session();
    bus.Alm_ack = 1'b1; cyc(0); bus.Alm_ack = 1'b0; cyc(0);
    checks++; if (bus.Alarm !== 1'b0 || obsv() !== expv())
      begin errors++; $display("FAIL final_ack got %b want Alarm=0 model %b", obsv(), expv()); end
  endtask

  task automatic test_fert();
    bus.Seco = 1'b0;
    pulse_req();
    start_session();
    checks++; if (bus.Adub !== 1'b1) begin errors++; $display("FAIL fert_idle got Adub=%b want 1", bus.Adub); end
    pulse_req();
    checks++; if (bus.Adub !== 1'b1 || obsv() !== expv())
      begin errors++; $display("FAIL fert_hold got %b want %b", obsv(), expv()); end
    bus.Seco = 1'b0;
    for (int i = 0; i < 200 && bus.Asp; i++) cyc(next_tick());
    checks++; if (bus.Adub !== 1'b0) begin errors++; $display("FAIL fert_exit got Adub=%b want 0", bus.Adub); end
    end_session();
    start_session();
    checks++; if (bus.Adub !== 1'b1) begin errors++; $display("FAIL fert_next got Adub=%b want 1", bus.Adub); end
    end_session();
    pulse_req(); pulse_req();
    start_session();
    checks++; if (bus.Adub !== 1'b1) begin errors++; $display("FAIL fert_double1 got Adub=%b want 1", bus.Adub); end
    end_session();
    start_session();
    checks++; if (bus.Adub !== 1'b0) begin errors++; $display("FAIL fert_double2 got Adub=%b want 0", bus.Adub); end
    end_session();
    pulse_req();
    start_session();
    pulse_req();
    reset = 1'b1; cyc(0); reset = 1'b0;
    checks++; if (bus.Asp !== 1'b0 || bus.Adub !== 1'b0 || bus.Est !== 2'b00)
      begin errors++; $display("FAIL reset_mid got Asp=%b Adub=%b Est=%b want 0/0/00", bus.Asp, bus.Adub, bus.Est); end
    start_session();
    checks++; if (bus.Adub !== 1'b0) begin errors++; $display("FAIL reset_pend got Adub=%b want 0", bus.Adub); end
    end_session();
  endtask

  task automatic test_random();
    int sp;
    for (int i = 0; i < 4000; i++) begin
      sp = (i < 2000) ? 12 : 150;
      if ($urandom_range(0, sp - 1) == 0) bus.Seco = ~bus.Seco;
      if ($urandom_range(0, 3 * sp) == 0) bus.Chuva = ~bus.Chuva;
      if ($urandom_range(0, 9) == 0) bus.Adub_req = ~bus.Adub_req;
      bus.Alm_ack = ($urandom_range(0, 29) == 0);
      reset = ($urandom_range(0, 499) == 0);
      cyc($urandom_range(0, 2) == 0);
      checks++;
      if (obsv() !== expv()) begin
        errors++; $display("FAIL random cyc=%0d got %b want %b", i, obsv(), expv());
      end
    end
    reset = 1'b0; bus.Alm_ack = 1'b0;
  endtask

  initial begin
    bus.tick = 1'b0; bus.Seco = 1'b0; bus.Chuva = 1'b0;
    bus.Adub_req = 1'b0; bus.Alm_ack = 1'b0;
    gap = 1;
    test_reset();
    test_latency();
    test_glitch();
    test_min_on();
    test_rain();
    test_timeout();
    test_fert();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
